// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register with EX-stage operand forwarding. It feeds the
// ALU's data1/data2/ALUCtrl inputs directly.
//
// Optional feature macro: ID_EX_FWD_EN
//   defined   : operands are forwarded from EX/MEM (first) or MEM/WB (second)
//               over the stale register-file values captured in ID.
//   undefined : operands come straight from the captured register-file
//               values; the exmem_*/memwb_* inputs are ignored.
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   stall_i, flush_i     hold stage / load bubble (flush has priority)
//   valid_i .. regwrite_i  decoded ID-stage instruction fields
//   exmem_*, memwb_*     later-stage writeback info used for forwarding
//   valid_o, aluctrl_o, rd_addr_o, regwrite_o   registered EX-stage control
//   data1_o, data2_o, store_data_o              ALU operands / store data
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alusrc_i,
  input  logic [CTRL_W-1:0] aluctrl_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              regwrite_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [CTRL_W-1:0] aluctrl_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              regwrite_o
);

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic              alusrc_q,   alusrc_d;
  logic [CTRL_W-1:0] aluctrl_q,  aluctrl_d;
  logic [REG_AW-1:0] rs_q,       rs_d;
  logic [REG_AW-1:0] rt_q,       rt_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              regwrite_q, regwrite_d;

  logic [DATA_W-1:0] fwd_a_c;
  logic [DATA_W-1:0] fwd_b_c;

  // Next-state: flush beats stall beats load.
  always_comb begin
    valid_d    = valid_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      aluctrl_d  = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      rs_data_d  = rs_data_i;
      rt_data_d  = rt_data_i;
      imm_d      = imm_i;
      alusrc_d   = alusrc_i;
      aluctrl_d  = aluctrl_i;
      rs_d       = rs_addr_i;
      rt_d       = rt_addr_i;
      rd_d       = rd_addr_i;
      regwrite_d = regwrite_i & valid_i;
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // Forwarding: later assignment wins, so EX/MEM (newest) overrides MEM/WB.
  // Register 0 is hard-wired and never forwarded.
  always_comb begin
    fwd_a_c = rs_data_q;
    if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_q)) fwd_a_c = memwb_data_i;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_q)) fwd_a_c = exmem_data_i;
  end

  always_comb begin
    fwd_b_c = rt_data_q;
    if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rt_q)) fwd_b_c = memwb_data_i;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rt_q)) fwd_b_c = exmem_data_i;
  end
`else
  // Hazards are resolved by upstream stalls; later-stage inputs are ignored.
  logic unused_fwd_c;
  assign unused_fwd_c = ^{exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                          memwb_regwrite_i, memwb_rd_i, memwb_data_i};
  assign fwd_a_c = rs_data_q;
  assign fwd_b_c = rt_data_q;
`endif

  assign valid_o      = valid_q;
  assign data1_o      = fwd_a_c;
  assign data2_o      = alusrc_q ? imm_q : fwd_b_c;
  assign store_data_o = fwd_b_c;
  assign aluctrl_o    = aluctrl_q;
  assign rd_addr_o    = rd_q;
  assign regwrite_o   = regwrite_q & valid_q;

endmodule
